// File: rtl/fcvt_arbiter.sv
// fcvt_arbiter: round-robin front end for a shared, fixed-latency float/int
// converter. Two requesters issue ftoi/itof operations; the arbiter registers
// the winning operand/opcode toward the converter, carries {live, id, tag}
// alongside it for LAT edges, and captures cvt_y into the originating
// requester's result registers as a one-cycle pulse.
//
// Timing for an operation accepted at edge E:
//   after E        : cvt_x/cvt_op hold the operand, operand-side meta is live
//   after E+k      : meta sits in tag stage k-1 (k = 1..LAT)
//   after E+LAT    : cvt_y valid, last tag stage names its owner
//   after E+LAT+1  : resN_valid/resN_data/resN_tag presented for one cycle
module fcvt_arbiter #(
    parameter int LAT  = 1,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_op,
    input  logic [31:0]     req0_data,
    input  logic [TAGW-1:0] req0_tag,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_op,
    input  logic [31:0]     req1_data,
    input  logic [TAGW-1:0] req1_tag,

    output logic            cvt_valid,
    output logic            cvt_op,
    output logic [31:0]     cvt_x,
    input  logic [31:0]     cvt_y,

    output logic            res0_valid,
    output logic [31:0]     res0_data,
    output logic [TAGW-1:0] res0_tag,

    output logic            res1_valid,
    output logic [31:0]     res1_data,
    output logic [TAGW-1:0] res1_tag,

    output logic            busy
);

    typedef struct packed {
        logic            live;
        logic            id;
        logic [TAGW-1:0] tag;
    } meta_t;

    // last_q holds the id granted most recently; reset to 1 so requester 0
    // wins the first contended cycle.
    logic            last_q, last_d;
    logic            gnt0, gnt1;

    logic            cvt_valid_q, cvt_valid_d;
    logic            cvt_op_q,    cvt_op_d;
    logic [31:0]     cvt_x_q,     cvt_x_d;
    logic            op_id_q,     op_id_d;
    logic [TAGW-1:0] op_tag_q,    op_tag_d;

    meta_t           meta_q [LAT];
    meta_t           meta_in;
    meta_t           meta_out;
    logic            pipe_live;

    logic            res0_valid_q, res0_valid_d;
    logic [31:0]     res0_data_q,  res0_data_d;
    logic [TAGW-1:0] res0_tag_q,   res0_tag_d;
    logic            res1_valid_q, res1_valid_d;
    logic [31:0]     res1_data_q,  res1_data_d;
    logic [TAGW-1:0] res1_tag_q,   res1_tag_d;

    // Round-robin grant; no grant at all while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // Pointer moves only on an actual grant; operand stage loads the winner.
    always_comb begin
        last_d      = last_q;
        cvt_valid_d = gnt0 | gnt1;
        cvt_op_d    = cvt_op_q;
        cvt_x_d     = cvt_x_q;
        op_id_d     = op_id_q;
        op_tag_d    = op_tag_q;
        if (gnt0) begin
            last_d   = 1'b0;
            cvt_op_d = req0_op;
            cvt_x_d  = req0_data;
            op_id_d  = 1'b0;
            op_tag_d = req0_tag;
        end else if (gnt1) begin
            last_d   = 1'b1;
            cvt_op_d = req1_op;
            cvt_x_d  = req1_data;
            op_id_d  = 1'b1;
            op_tag_d = req1_tag;
        end
    end

    // Arbitration pointer and operand register toward the converter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q      <= 1'b1;
            cvt_valid_q <= 1'b0;
            cvt_op_q    <= 1'b0;
            cvt_x_q     <= '0;
            op_id_q     <= 1'b0;
            op_tag_q    <= '0;
        end else begin
            last_q      <= last_d;
            cvt_valid_q <= cvt_valid_d;
            cvt_op_q    <= cvt_op_d;
            cvt_x_q     <= cvt_x_d;
            op_id_q     <= op_id_d;
            op_tag_q    <= op_tag_d;
        end
    end

    assign meta_in  = {cvt_valid_q, op_id_q, op_tag_q};
    assign meta_out = meta_q[LAT-1];

    // Tag pipe: shifts every edge with no stall, so its last stage lines up
    // with the converter output. Reset clears every live bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            meta_q[0] <= meta_in;
            for (int i = 1; i < LAT; i++) begin
                meta_q[i] <= meta_q[i-1];
            end
        end
    end

    // Any live operation still travelling through the tag pipe.
    always_comb begin
        pipe_live = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            pipe_live = pipe_live | meta_q[i].live;
        end
    end

    // Result steering: only the owning requester's registers update; the
    // other side keeps its last data/tag.
    always_comb begin
        res0_valid_d = meta_out.live & ~meta_out.id;
        res1_valid_d = meta_out.live &  meta_out.id;
        res0_data_d  = res0_data_q;
        res0_tag_d   = res0_tag_q;
        res1_data_d  = res1_data_q;
        res1_tag_d   = res1_tag_q;
        if (res0_valid_d) begin
            res0_data_d = cvt_y;
            res0_tag_d  = meta_out.tag;
        end
        if (res1_valid_d) begin
            res1_data_d = cvt_y;
            res1_tag_d  = meta_out.tag;
        end
    end

    // Result registers; valid bits fall after one cycle unless refilled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res0_valid_q <= 1'b0;
            res0_data_q  <= '0;
            res0_tag_q   <= '0;
            res1_valid_q <= 1'b0;
            res1_data_q  <= '0;
            res1_tag_q   <= '0;
        end else begin
            res0_valid_q <= res0_valid_d;
            res0_data_q  <= res0_data_d;
            res0_tag_q   <= res0_tag_d;
            res1_valid_q <= res1_valid_d;
            res1_data_q  <= res1_data_d;
            res1_tag_q   <= res1_tag_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign cvt_valid  = cvt_valid_q;
    assign cvt_op     = cvt_op_q;
    assign cvt_x      = cvt_x_q;

    assign res0_valid = res0_valid_q;
    assign res0_data  = res0_data_q;
    assign res0_tag   = res0_tag_q;
    assign res1_valid = res1_valid_q;
    assign res1_data  = res1_data_q;
    assign res1_tag   = res1_tag_q;

    assign busy = cvt_valid_q | pipe_live | res0_valid_q | res1_valid_q;

endmodule

// File: tb/tb_fcvt_arbiter.sv
// Bench for fcvt_arbiter: one LAT=1 and one LAT=3 instance share the same
// requester stimulus; each has its own converter model and result scoreboard.
module tb_fcvt_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    logic        req0_valid = 1'b0, req0_op = 1'b0;
    logic [31:0] req0_data  = '0;
    logic [4:0]  req0_tag   = '0;
    logic        req1_valid = 1'b0, req1_op = 1'b0;
    logic [31:0] req1_data  = '0;
    logic [4:0]  req1_tag   = '0;

    logic [1:0]       rdy0, rdy1, cv, co, r0v, r1v, bz;
    logic [1:0][31:0] cx, cy, d0, d1;
    logic [1:0][4:0]  t0, t1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit tb_last  = 1'b1;

    typedef struct {
        logic        op;
        logic [31:0] data;
        logic [4:0]  tag;
        logic [31:0] res;
    } op_t;

    typedef struct {
        logic        id;
        logic [4:0]  tag;
        logic [31:0] res;
        int          due;
    } exp_t;

    op_t  rq0[$], rq1[$];
    exp_t sb0[$], sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fcvt_arbiter #(.LAT(1), .TAGW(5)) u_lat1 (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_op(req0_op),
        .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_op(req1_op),
        .req1_data(req1_data), .req1_tag(req1_tag),
        .cvt_valid(cv[0]), .cvt_op(co[0]), .cvt_x(cx[0]), .cvt_y(cy[0]),
        .res0_valid(r0v[0]), .res0_data(d0[0]), .res0_tag(t0[0]),
        .res1_valid(r1v[0]), .res1_data(d1[0]), .res1_tag(t1[0]),
        .busy(bz[0])
    );

    fcvt_arbiter #(.LAT(3), .TAGW(5)) u_lat3 (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_op(req0_op),
        .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_op(req1_op),
        .req1_data(req1_data), .req1_tag(req1_tag),
        .cvt_valid(cv[1]), .cvt_op(co[1]), .cvt_x(cx[1]), .cvt_y(cy[1]),
        .res0_valid(r0v[1]), .res0_data(d0[1]), .res0_tag(t0[1]),
        .res1_valid(r1v[1]), .res1_data(d1[1]), .res1_tag(t1[1]),
        .busy(bz[1])
    );

    function automatic logic [31:0] f_ftoi(input logic [31:0] v);
        int          e;
        logic [31:0] m, r;
        e = int'(v[30:23]);
        if (e < 127) return 32'h0;
        if (e > 157) return v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        m = {8'h00, 1'b1, v[22:0]};
        if (e >= 150) r = m << (e - 150);
        else          r = m >> (150 - e);
        return v[31] ? (~r + 32'd1) : r;
    endfunction

    function automatic logic [31:0] f_itof(input logic [31:0] v);
        logic [31:0] m, f;
        logic [7:0]  e;
        int          p;
        if (v == 32'h0) return 32'h0;
        m = v[31] ? (~v + 32'd1) : v;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = 8'(127 + p);
        if (p >= 23) f = m >> (p - 23);
        else         f = m << (23 - p);
        return {v[31], e, f[22:0]};
    endfunction

    function automatic logic [31:0] cvt_model(input logic op, input logic [31:0] x);
        return op ? f_itof(x) : f_ftoi(x);
    endfunction

    // Converter models: LAT registers from operand to cvt_y.
    logic [31:0] ya;
    logic [31:0] yb [3];
    always @(posedge clk) begin
        ya    <= cvt_model(co[0], cx[0]);
        yb[0] <= cvt_model(co[1], cx[1]);
        yb[1] <= yb[0];
        yb[2] <= yb[1];
    end
    assign cy[0] = ya;
    assign cy[1] = yb[2];

    task automatic chk(input string nm, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", nm, k, obs, exp);
        end
    endtask

    task automatic add_op(input bit rid, input logic op, input logic [31:0] data,
                          input logic [4:0] tag, input logic [31:0] res);
        op_t a;
        a = '{op, data, tag, res};
        if (rid) rq1.push_back(a);
        else     rq0.push_back(a);
    endtask

    task automatic add_model_op(input bit rid, input logic op, input logic [31:0] data,
                                input logic [4:0] tag);
        add_op(rid, op, data, tag, cvt_model(op, data));
    endtask

    task automatic drive_heads();
        if (rq0.size() != 0) begin
            req0_valid = 1'b1;
            req0_op    = rq0[0].op;
            req0_data  = rq0[0].data;
            req0_tag   = rq0[0].tag;
        end else begin
            req0_valid = 1'b0;
        end
        if (rq1.size() != 0) begin
            req1_valid = 1'b1;
            req1_op    = rq1[0].op;
            req1_data  = rq1[0].data;
            req1_tag   = rq1[0].tag;
        end else begin
            req1_valid = 1'b0;
        end
    endtask

    task automatic check_dut(input int k, input bit has, input exp_t e, output bit popped);
        logic        exp_pulse;
        logic [31:0] d;
        logic [4:0]  t;
        popped = 1'b0;
        chk("busy", k, bz[k], has);
        chk("both_res", k, r0v[k] & r1v[k], 0);
        exp_pulse = has && (e.due == cyc);
        chk("res_pulse", k, r0v[k] | r1v[k], exp_pulse);
        if (exp_pulse) begin
            d = e.id ? d1[k] : d0[k];
            t = e.id ? t1[k] : t0[k];
            chk("res_id", k, r1v[k], e.id);
            chk("res_data", k, d, e.res);
            chk("res_tag", k, t, e.tag);
        end
        popped = has && (e.due <= cyc);
    endtask

    // One clock: present heads, check grants against the round-robin model,
    // record accepted ops, then check operand register and results.
    task automatic tick();
        logic e0, e1;
        op_t  a;
        int   acc;
        exp_t h;
        bit   has, pop;
        drive_heads();
        #1;
        e0 = req0_valid && (!req1_valid || tb_last);
        e1 = req1_valid && (!req0_valid || !tb_last);
        for (int k = 0; k < 2; k++) begin
            chk("ready0", k, rdy0[k], e0);
            chk("ready1", k, rdy1[k], e1);
        end
        acc = cyc + 1;
        a   = '{1'b0, 32'h0, 5'h0, 32'h0};
        if (e0) begin
            a = rq0.pop_front();
            tb_last = 1'b0;
        end else if (e1) begin
            a = rq1.pop_front();
            tb_last = 1'b1;
        end
        if (e0 || e1) begin
            sb0.push_back('{e1, a.tag, a.res, acc + 2});
            sb1.push_back('{e1, a.tag, a.res, acc + 4});
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("cvt_valid", k, cv[k], e0 | e1);
            if (e0 || e1) begin
                chk("cvt_x", k, cx[k], a.data);
                chk("cvt_op", k, co[k], a.op);
            end
        end
        has = sb0.size() != 0;
        h   = has ? sb0[0] : '{1'b0, 5'h0, 32'h0, 0};
        check_dut(0, has, h, pop);
        if (pop) void'(sb0.pop_front());
        has = sb1.size() != 0;
        h   = has ? sb1[0] : '{1'b0, 5'h0, 32'h0, 0};
        check_dut(1, has, h, pop);
        if (pop) void'(sb1.pop_front());
    endtask

    function automatic int pending();
        return sb0.size() + sb1.size() + rq0.size() + rq1.size();
    endfunction

    task automatic drain();
        for (int i = 0; i < 40 && pending() != 0; i++) tick();
        chk("drain_pending", 0, pending(), 0);
    endtask

    task automatic chk_zero_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready0", k, rdy0[k], 0);
            chk("rst_ready1", k, rdy1[k], 0);
            chk("rst_cvt_valid", k, cv[k], 0);
            chk("rst_cvt_op", k, co[k], 0);
            chk("rst_cvt_x", k, cx[k], 0);
            chk("rst_res0_valid", k, r0v[k], 0);
            chk("rst_res1_valid", k, r1v[k], 0);
            chk("rst_res0_data", k, d0[k], 0);
            chk("rst_res1_data", k, d1[k], 0);
            chk("rst_res0_tag", k, t0[k], 0);
            chk("rst_res1_tag", k, t1[k], 0);
            chk("rst_busy", k, bz[k], 0);
        end
    endtask

    task automatic clear_bench();
        rq0.delete();
        rq1.delete();
        sb0.delete();
        sb1.delete();
        tb_last = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requesters asserting valid: readies must stay low.
        #2 rstn = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rstn = 1'b1;
        tick();

        // Single ftoi from requester 0.
        add_op(1'b0, 1'b0, 32'h4049_0FDB, 5'd3, 32'h0000_0003);
        tick();
        drain();

        // Contention: both valid for six cycles, grants alternate.
        add_model_op(1'b0, 1'b1, 32'h0000_0001, 5'd10);
        add_model_op(1'b0, 1'b1, 32'h0000_0002, 5'd11);
        add_model_op(1'b0, 1'b1, 32'h0000_0003, 5'd12);
        add_model_op(1'b1, 1'b0, 32'h4120_0000, 5'd20);
        add_model_op(1'b1, 1'b0, 32'hC000_0000, 5'd21);
        add_model_op(1'b1, 1'b0, 32'h3F00_0000, 5'd22);
        drain();

        // Back-to-back itof from requester 1, including a zero result.
        add_op(1'b1, 1'b1, 32'h0000_0007, 5'd7, 32'h40E0_0000);
        add_op(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd8, 32'hBF80_0000);
        add_op(1'b1, 1'b1, 32'h0000_0000, 5'd9, 32'h0000_0000);
        drain();

        // Fairness after idle: requester 1 was served last, so 0 wins now.
        tick();
        tick();
        add_model_op(1'b0, 1'b1, 32'h0000_0005, 5'd1);
        add_model_op(1'b1, 1'b1, 32'h0000_0006, 5'd2);
        drive_heads();
        #1;
        chk("fair_req0_first", 0, rdy0[0], 1);
        chk("fair_req1_wait", 0, rdy1[0], 0);
        drain();

        // Reset one cycle after an accept: op is dropped, priority restored.
        add_model_op(1'b1, 1'b1, 32'h0000_0009, 5'd17);
        tick();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_zero_outputs();
        clear_bench();
        drive_heads();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (6) tick();
        add_model_op(1'b1, 1'b0, 32'h4080_0000, 5'd30);
        add_model_op(1'b0, 1'b0, 32'h40A0_0000, 5'd31);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
